// File: rtl/fifo_pkg.sv
// Shared defaults and status bundle for the programmable synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_prog_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Storage is deliberately not reset, so it maps onto RAM primitives.
module fifo_prog_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with occupancy count, programmable thresholds, FWFT or
// registered read, synchronous flush and sticky overflow/underflow flags.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter bit FWFT          = 1'b1,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        err_clr,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] AF_C    = (PW+1)'(AFULL_THRESH);
  localparam logic [PW:0] AE_C    = (PW+1)'(AEMPTY_THRESH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $fatal(1, "fifo_prog: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_WIDTH <= 0) begin : g_chk_width
    $fatal(1, "fifo_prog: DATA_WIDTH must be > 0");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > FIFO_DEPTH) begin : g_chk_thr
    $fatal(1, "fifo_prog: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= FIFO_DEPTH");
  end

  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  rd_acc, wr_acc, ovf_evt, unf_evt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status_t          st;

  // Extra pointer MSB disambiguates full from empty; the difference is the count.
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    st              = '0;
    st.empty        = (count == '0);
    st.full         = (count == DEPTH_C);
    st.almost_full  = (count >= AF_C);
    st.almost_empty = (count <= AE_C);
    st.overflow     = ovf_q;
    st.underflow    = unf_q;
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
  assign rd_acc  = rd_en && !st.empty && !flush;
  assign wr_acc  = wr_en && (!st.full || rd_acc) && !flush;
  assign ovf_evt = wr_en && !flush && !wr_acc;
  assign unf_evt = rd_en && !flush && st.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A new error outranks a clear arriving in the same cycle.
    ovf_d = ovf_evt | (ovf_q & ~err_clr);
    unf_d = unf_evt | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_prog_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[PW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[PW-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = !st.empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_rdata;
      end
    end

    assign rd_data  = rdata_q;
    assign rd_valid = rvalid_q;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
  a_full_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(st.full && st.empty));
  a_wr_reject:   assert property (@(posedge clk) disable iff (!rst_n)
                                  (wr_en && !flush && !wr_acc) |=> (wr_ptr_q == $past(wr_ptr_q)));
  a_rd_reject:   assert property (@(posedge clk) disable iff (!rst_n)
                                  (rd_en && !flush && !rd_acc) |=> (rd_ptr_q == $past(rd_ptr_q)));

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
- Parametrised successor to the basic synchronous FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, selectable read mode (first-word-fall-through or registered standard), synchronous flush, and sticky overflow/underflow error flags.
- Used as the general-purpose buffer between pipeline stages and peripherals; the error and threshold outputs feed status/CSR logic.

Parameters:
- DATA_WIDTH, 16, word width in bits (>0).
- FIFO_DEPTH, 16, number of entries; power of 2, >=2.
- FWFT, 1, 1 = first-word-fall-through read; 0 = standard read with registered data.
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- err_clr  in  1  synchronous clear of sticky error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request / pop.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data holds a valid word.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write was rejected.
- underflow  out  1  sticky: read was rejected.

Behaviour:
- Reset (async assert, sync release to clk): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, rd_valid=0, rd_data=0 (FWFT=0). Storage is not reset.
- Pointers are POINTER_WIDTH+1 bits. count = w - r (modular). Index = low bits. Wrap-around is natural.
- Read accept: rd_en && !empty. Rejected read sets underflow.
- Write accept: wr_en && (!full || read accepted same cycle). Rejected write sets overflow; memory and pointers are unchanged.
- Simultaneous accepted read+write: count unchanged; full stays full; write lands in the slot freed that cycle.
- Write to empty with rd_en in the same cycle: read rejected, underflow set, write accepted.
- FWFT=1:
  - rd_data = mem[r_idx] combinationally; rd_valid = !empty.
  - A write to an empty FIFO is visible the next cycle (1-cycle latency).
  - rd_en pops the current word.
- FWFT=0:
  - An accepted read registers mem[r_idx] into rd_data on that edge; rd_valid=1 for exactly that following cycle, else 0.
  - rd_data holds its last value when no read is accepted.
- flush:
  - r=w=0, count=0 next cycle; overrides wr_en/rd_en that cycle (neither accepted, no error set).
  - FWFT=0: rd_valid=0 next cycle.
  - Sticky flags are unaffected.
- err_clr clears overflow/underflow; an error event in the same cycle wins (flag stays 1).
- All status outputs derive combinationally from the registered pointers; no output depends combinationally on wr_en/rd_en.
- Elaboration checks ($fatal):
  - FIFO_DEPTH is a power of 2 and >=2.
  - DATA_WIDTH > 0.
  - 0 <= AEMPTY_THRESH < AFULL_THRESH <= FIFO_DEPTH.
- Assertions:
  - count <= FIFO_DEPTH.
  - full and empty never both 1.
  - No pointer change on a rejected op.

Decomposition:
- fifo_pkg holds the DATA_WIDTH/FIFO_DEPTH defaults and a fifo_status_t struct {full, empty, almost_full, almost_empty, overflow, underflow}.
- One natural sub-module, fifo_prog_mem: the storage array with write port and async read port, reusable for BRAM inference.
- Pointer, flag and read-register logic stay in fifo_prog.

Test Plan:
- Fill: DEPTH=16, AFULL=14, 16 writes of 0x0000..0x000F from reset -> count tracks 1..16; almost_empty drops at count 3; almost_full rises at count 14; full at 16. A 17th write -> overflow=1, count=16.
- FWFT=1: drain 16 -> data 0x0000..0x000F in order, empty after the last pop. An extra rd_en -> underflow=1. err_clr -> both flags 0.
- Wrap: 40 words pushed/popped with occupancy kept 5..12 -> output order is exact, no flags set.
- Full + simultaneous rd/wr: full FIFO, rd_en=wr_en=1 with 0xBEEF -> count stays 16, no overflow; 0xBEEF emerges 16th.
- FWFT=0: write 0x1234, then rd_en -> rd_data=0x1234 and rd_valid=1 exactly one cycle after the accepted read, then 0.
- Flush/reset: 8 entries stored; flush asserted with wr_en=1 -> count=0, empty=1, flags unchanged. Then write 3 entries and assert rst_n=0 mid-cycle -> outputs reach reset values without waiting for a clock edge.
